// File: rtl/scancode_pkg.sv
`default_nettype none
// ============================================================================
// Module   : scancode_pkg
// Brief    : Shared constants, prefix-state encoding and the Tandy 1000 remap.
// Revision : 1.0
// ============================================================================
package scancode_pkg;

    localparam logic [7:0] PFX_E0 = 8'hE0;
    localparam logic [7:0] PFX_E1 = 8'hE1;

    localparam logic [7:0] FS_LSHIFT_MAKE  = 8'h2A;
    localparam logic [7:0] FS_LSHIFT_BREAK = 8'hAA;
    localparam logic [7:0] FS_RSHIFT_MAKE  = 8'h36;
    localparam logic [7:0] FS_RSHIFT_BREAK = 8'hB6;

    typedef enum logic [1:0] {
        PFX_IDLE    = 2'd0,
        PFX_E0_SEEN = 2'd1,
        PFX_E1_A    = 2'd2,
        PFX_E1_B    = 2'd3
    } pfx_state_e;

    function automatic logic is_fake_shift(input logic [7:0] code);
        return (code == FS_LSHIFT_MAKE)  || (code == FS_LSHIFT_BREAK) ||
               (code == FS_RSHIFT_MAKE)  || (code == FS_RSHIFT_BREAK);
    endfunction

    // Make/break is handled by the caller; only the 7-bit key code is remapped.
    function automatic logic [6:0] tandy_remap(input logic [6:0] code, input logic e0);
        logic [6:0] w_mapped;
        w_mapped = code;
        case (code)
            7'h48:   if (e0)  w_mapped = 7'h29;
            7'h4B:   if (e0)  w_mapped = 7'h2B;
            7'h50:   if (e0)  w_mapped = 7'h4A;
            7'h4D:   if (e0)  w_mapped = 7'h4E;
            7'h1C:   if (e0)  w_mapped = 7'h57;
            7'h47:   if (e0)  w_mapped = 7'h58;
            7'h4A:   if (!e0) w_mapped = 7'h53;
            7'h4E:   if (!e0) w_mapped = 7'h55;
            7'h53:   if (!e0) w_mapped = 7'h56;
            7'h57:   w_mapped = 7'h59;
            7'h58:   w_mapped = 7'h5A;
            default: w_mapped = code;
        endcase
        return w_mapped;
    endfunction

endpackage
`default_nettype wire

// File: rtl/scancode_translator_if.sv
`default_nettype none
// ============================================================================
// Module   : scancode_translator_if
// Brief    : Translated-byte output stream with valid/ack handshake.
// Revision : 1.0
// ============================================================================
interface scancode_translator_if;

    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ack;

    modport master (output out_data, output out_valid, input out_ack);
    modport slave  (input out_data, input out_valid, output out_ack);

endinterface
`default_nettype wire

// File: rtl/scancode_fifo.sv
`default_nettype none
// ============================================================================
// Module   : scancode_fifo
// Brief    : Synchronous byte FIFO with write, pop, clear, count, full, empty.
// Revision : 1.0
// ============================================================================
module scancode_fifo #(
    parameter int DEPTH = 8
) (
    input  wire                      clock,
    input  wire                      reset,
    input  wire                      wr_en,
    input  wire  [7:0]               wr_data,
    input  wire                      pop,
    input  wire                      clear,
    output logic [7:0]               rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int              c_AW   = $clog2(DEPTH);
    localparam int              c_CW   = c_AW + 1;
    localparam logic [c_AW:0]   c_FULL = c_CW'(DEPTH);

    logic [7:0]      r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic            w_pop;
    logic            w_push;

    assign empty  = (r_count == '0);
    assign full   = (r_count == c_FULL);
    assign w_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
    assign w_push = wr_en & (~full | w_pop);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
            r_count <= r_count + c_CW'(w_push) - c_CW'(w_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (w_push && !clear) r_mem[r_wr_ptr] <= wr_data;
    end

    assign rd_data = empty ? 8'h00 : r_mem[r_rd_ptr];
    assign count   = r_count;

endmodule
`default_nettype wire

// File: rtl/scancode_translator.sv
`default_nettype none
// ============================================================================
// Module   : scancode_translator
// Brief    : IRQ edge capture, E0/E1 prefix tracking, XT/Tandy remap, FIFO out.
// Revision : 1.0
// ============================================================================
module scancode_translator
    import scancode_pkg::*;
#(
    parameter int FIFO_DEPTH      = 8,
    parameter bit DROP_PREFIX     = 1'b1,
    parameter bit DROP_FAKE_SHIFT = 1'b1
) (
    input  wire                           clock,
    input  wire                           reset,
    input  wire                           keybord_irq,
    input  wire  [7:0]                    scancode,
    input  wire                           tandy_mode,
    input  wire                           clear,
    scancode_translator_if.master         out_bus,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam logic [1:0] c_ST_IDLE = PFX_IDLE;
    localparam logic [1:0] c_ST_E0   = PFX_E0_SEEN;
    localparam logic [1:0] c_ST_E1_A = PFX_E1_A;
    localparam logic [1:0] c_ST_E1_B = PFX_E1_B;

    logic       r_prev_irq;
    logic [1:0] r_state;
    logic [1:0] w_next_state;
    logic       w_capture;
    logic       w_e0;
    logic       w_raw;
    logic       w_fake;
    logic       w_keep;
    logic [7:0] w_xlat;
    logic       r_stage_wr;
    logic [7:0] r_stage_data;
    logic       r_overflow;
    logic       w_full;
    logic       w_empty;
    logic       w_pop;

    assign w_capture = keybord_irq & ~r_prev_irq;

    // w_raw marks prefix bytes and E1-sequence bytes: never remapped, optionally dropped.
    always_comb begin
        w_next_state = r_state;
        w_e0         = 1'b0;
        w_raw        = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (scancode == PFX_E0) begin
                    w_next_state = c_ST_E0;
                    w_raw        = 1'b1;
                end else if (scancode == PFX_E1) begin
                    w_next_state = c_ST_E1_A;
                    w_raw        = 1'b1;
                end
            end
            c_ST_E0: begin
                if (scancode == PFX_E0) begin
                    w_raw = 1'b1;
                end else begin
                    w_e0         = 1'b1;
                    w_next_state = c_ST_IDLE;
                end
            end
            c_ST_E1_A: begin
                w_next_state = c_ST_E1_B;
                w_raw        = 1'b1;
            end
            c_ST_E1_B: begin
                w_next_state = c_ST_IDLE;
                w_raw        = 1'b1;
            end
            default: w_next_state = c_ST_IDLE;
        endcase

        w_fake = w_e0 & is_fake_shift(scancode);
        w_xlat = (tandy_mode && !w_raw) ? {scancode[7], tandy_remap(scancode[6:0], w_e0)}
                                        : scancode;
        w_keep = !(DROP_PREFIX && w_raw) && !(DROP_FAKE_SHIFT && w_fake);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_prev_irq   <= 1'b0;
            r_state      <= c_ST_IDLE;
            r_stage_wr   <= 1'b0;
            r_stage_data <= 8'h00;
            r_overflow   <= 1'b0;
        end else begin
            r_prev_irq <= keybord_irq;
            r_stage_wr <= w_capture & w_keep;
            if (w_capture) begin
                r_state      <= w_next_state;
                r_stage_data <= w_xlat;
            end
            if (clear)
                r_overflow <= 1'b0;
            else if (r_stage_wr && w_full && !w_pop)
                r_overflow <= 1'b1;
        end
    end

    assign w_pop = out_bus.out_ack & ~w_empty;

    scancode_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (r_stage_wr),
        .wr_data (r_stage_data),
        .pop     (out_bus.out_ack),
        .clear   (clear),
        .rd_data (out_bus.out_data),
        .count   (fifo_count),
        .full    (w_full),
        .empty   (w_empty)
    );

    assign out_bus.out_valid = ~w_empty;
    assign overflow          = r_overflow;

endmodule
`default_nettype wire
